serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that time-shares one full adder cell to add two WIDTH-bit operands, LSB first, one bit per clock. It accepts an operation over a valid/ready request handshake, sequences the single full adder for WIDTH cycles, and holds the result until a valid/ready response handshake completes. It is the sequencing layer above the combinational adder cells, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder.sv | 21 ++
 rtl/half_adder.sv | 15 +
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder controller.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller state encoding (S_IDLE, S_RUN, S_DONE; 2'd3 unused)
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder built from two half_adder cells.
//   a, b : addend bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s1, c1, c2;

   half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
   half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

   assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder cell.
//   a, b : addend bits
//   s    : sum bit
//   c    : carry bit
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per clock through a
// single full_adder cell. Request/response use valid/ready handshakes.
//   clk, reset                 : clock, async active-high reset
//   start_valid/start_ready    : request handshake (ready only in IDLE)
//   a, b, c_in                 : operands, sampled on request accept
//   result_valid/result_ready  : response handshake (valid only in DONE)
//   sum, c_out, ovf            : registered result, held until the next DONE
//   busy                       : high in RUN or DONE
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry, msb_cin;
   logic             fa_s, fa_co;
   logic             accept, run_last;
   logic             unused_sum_lsb;

   assign accept   = start_valid && start_ready;
   assign run_last = (state == S_RUN) && (cnt == CNT_LAST);

   // The only adder in the datapath: one bit per cycle.
   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_co)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; the unused encoding falls back to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_valid)  state_nxt = S_RUN;
         S_RUN:   if (run_last)     state_nxt = S_DONE;
         S_DONE:  if (result_ready) state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // Handshake/status outputs decoded from the state register
   always_comb begin
      start_ready  = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b0;
      case (state)
         S_IDLE: start_ready = 1'b1;
         S_RUN:  busy        = 1'b1;
         S_DONE: begin
            result_valid = 1'b1;
            busy         = 1'b1;
         end
         default: ;
      endcase
   end

   // Serial datapath: operand/sum shifters, carry, bit counter, result regs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         msb_cin <= 1'b0;
         sum     <= '0;
         c_out   <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         carry  <= c_in;
         cnt    <= '0;
         sum_sh <= '0;
      end else if (state == S_RUN) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
         carry  <= fa_co;
         // Carry out of bit WIDTH-2 is the carry into the MSB
         if (cnt == CNT_PEN) msb_cin <= fa_co;
         if (cnt == CNT_LAST) begin
            sum   <= {fa_s, sum_sh[WIDTH-1:1]};
            c_out <= fa_co;
            ovf   <= msb_cin ^ fa_co;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Bit 0 of sum_sh is shifted out before the final result is captured
   assign unused_sum_lsb = sum_sh[0];

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl at WIDTH=8
// and WIDTH=3, with directed vectors, handshake corner cases and random
// back-to-back operations checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

   logic clk;
   logic reset;

   logic       sv8, sr8, rv8, rr8, ci8, co8, ov8, bz8;
   logic [7:0] a8, b8, sum8;
   logic       sv3, sr3, rv3, rr3, ci3, co3, ov3, bz3;
   logic [2:0] a3, b3, sum3;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int          w;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } res_t;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset),
      .start_valid(sv8), .start_ready(sr8),
      .a(a8), .b(b8), .c_in(ci8),
      .result_valid(rv8), .result_ready(rr8),
      .sum(sum8), .c_out(co8), .ovf(ov8), .busy(bz8)
   );

   serial_adder_ctrl #(.WIDTH(3)) dut3 (
      .clk(clk), .reset(reset),
      .start_valid(sv3), .start_ready(sr3),
      .a(a3), .b(b3), .c_in(ci3),
      .result_valid(rv3), .result_ready(rr3),
      .sum(sum3), .c_out(co3), .ovf(ov3), .busy(bz3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_assert++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   task automatic drive(input int w, input logic sv, input logic [31:0] a, input logic [31:0] b,
                        input logic ci);
      if (w == 8) begin
         sv8 = sv; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci;
      end else begin
         sv3 = sv; a3 = a[2:0]; b3 = b[2:0]; ci3 = ci;
      end
   endtask

   task automatic set_rr(input int w, input logic rr);
      if (w == 8) rr8 = rr;
      else        rr3 = rr;
   endtask

   task automatic sample(input int w, output logic sr, output logic rv, output logic bz,
                         output logic [31:0] s, output logic co, output logic ov);
      if (w == 8) begin
         sr = sr8; rv = rv8; bz = bz8; s = 32'(sum8); co = co8; ov = ov8;
      end else begin
         sr = sr3; rv = rv3; bz = bz3; s = 32'(sum3); co = co3; ov = ov3;
      end
   endtask

   // Reference: plain unsigned and signed arithmetic on w-bit operands
   function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, output logic [31:0] s, output logic co,
                                 output logic ov);
      longint unsigned m    = (64'd1 << w) - 64'd1;
      longint unsigned tot  = (64'(a) & m) + (64'(b) & m) + (ci ? 64'd1 : 64'd0);
      longint          half = longint'(64'd1 << (w - 1));
      longint          sa   = longint'(64'(a) & m);
      longint          sb   = longint'(64'(b) & m);
      longint          r;
      if (sa >= half) sa = sa - 2 * half;
      if (sb >= half) sb = sb - 2 * half;
      r  = sa + sb + (ci ? 64'sd1 : 64'sd0);
      s  = 32'(tot & m);
      co = ((tot >> w) & 64'd1) != 64'd0;
      ov = (r >= half) || (r < -half);
   endfunction

   // Starts from IDLE, #1 after an edge; returns #1 after the edge that raised result_valid
   task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                        output logic [31:0] s, output logic co, output logic ov, output int lat);
      logic sr, rv, bz;
      sample(w, sr, rv, bz, s, co, ov);
      check1("ready_before_accept", sr, 1'b1);
      drive(w, 1'b1, a, b, ci);
      @(posedge clk); #1;
      drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         sample(w, sr, rv, bz, s, co, ov);
      end while (!rv && lat < 40);
      if (!rv) fail_now("result_valid_wait");
   endtask

   // Back-to-back random operations with start_valid held and result_ready high
   task automatic stream(input int w, input int nops);
      res_t        q[$];
      res_t        e, got;
      logic [31:0] ca, cb;
      logic        cc, sr, rv, bz, acc;
      int          cyc = 0, last_acc = -1, done = 0, accepts = 0;
      int          bound = nops * (w + 2) + 100;
      set_rr(w, 1'b1);
      ca = $urandom; cb = $urandom; cc = 1'($urandom);
      drive(w, 1'b1, ca, cb, cc);
      while (done < nops && cyc < bound) begin
         sample(w, sr, rv, bz, got.s, got.co, got.ov);
         if (rv) begin
            if (q.size() == 0) begin
               fail_now("unexpected_result");
            end else begin
               e = q.pop_front();
               check32("rand_sum", got.s, e.s);
               check1("rand_cout", got.co, e.co);
               check1("rand_ovf", got.ov, e.ov);
            end
            done++;
         end
         acc = sr && (accepts < nops);
         if (acc) begin
            model(w, ca, cb, cc, e.s, e.co, e.ov);
            q.push_back(e);
            if (last_acc >= 0) check32("accept_spacing", 32'(cyc - last_acc), 32'(w + 2));
            last_acc = cyc;
            accepts++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            ca = $urandom; cb = $urandom; cc = 1'($urandom);
            drive(w, (accepts < nops), ca, cb, cc);
         end
      end
      if (done < nops) fail_now("stream_results");
      drive(w, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      vec_t        vecs[11];
      logic [31:0] s, s_hold;
      logic        co, ov, sr, rv, bz;
      int          lat;

      vecs[0]  = '{8, 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b0, 1'b1};
      vecs[1]  = '{8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0};
      vecs[2]  = '{8, 32'h7F, 32'h00, 1'b1, 32'h80, 1'b0, 1'b1};
      vecs[3]  = '{8, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1};
      vecs[4]  = '{8, 32'h00, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0};
      vecs[5]  = '{8, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 1'b0};
      vecs[6]  = '{8, 32'hC0, 32'hC0, 1'b0, 32'h80, 1'b1, 1'b0};
      vecs[7]  = '{3, 32'h7,  32'h1,  1'b0, 32'h0,  1'b1, 1'b0};
      vecs[8]  = '{3, 32'h3,  32'h0,  1'b1, 32'h4,  1'b0, 1'b1};
      vecs[9]  = '{3, 32'h4,  32'h4,  1'b0, 32'h0,  1'b1, 1'b1};
      vecs[10] = '{3, 32'h5,  32'h2,  1'b0, 32'h7,  1'b0, 1'b0};

      reset = 1'b1;
      drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(3, 1'b0, 32'd0, 32'd0, 1'b0);
      rr8 = 1'b1; rr3 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int w = 3; w <= 8; w += 5) begin
         sample(w, sr, rv, bz, s, co, ov);
         check1("reset_start_ready", sr, 1'b1);
         check1("reset_result_valid", rv, 1'b0);
         check1("reset_busy", bz, 1'b0);
         check32("reset_sum", s, 32'd0);
         check1("reset_cout", co, 1'b0);
         check1("reset_ovf", ov, 1'b0);
      end
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // Directed vectors, result_ready high: DONE lasts exactly one cycle
      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].ci, s, co, ov, lat);
         check32("vec_sum", s, vecs[i].s);
         check1("vec_cout", co, vecs[i].co);
         check1("vec_ovf", ov, vecs[i].ov);
         check32("vec_latency", 32'(lat), 32'(vecs[i].w));
         @(posedge clk); #1;
         sample(vecs[i].w, sr, rv, bz, s, co, ov);
         check1("vec_valid_one_cycle", rv, 1'b0);
         check1("vec_ready_after_done", sr, 1'b1);
         check32("vec_sum_held_idle", s, vecs[i].s);
      end

      // Back-pressure: result_ready low while in DONE
      set_rr(8, 1'b0);
      do_op(8, 32'h5A, 32'h3C, 1'b0, s_hold, co, ov, lat);
      check32("bp_sum", s_hold, 32'h96);
      check32("bp_latency", 32'(lat), 32'd8);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         sample(8, sr, rv, bz, s, co, ov);
         check1("bp_valid_held", rv, 1'b1);
         check32("bp_sum_held", s, 32'h96);
         check1("bp_cout_held", co, 1'b0);
         check1("bp_ovf_held", ov, 1'b1);
         check1("bp_start_ready", sr, 1'b0);
         check1("bp_busy", bz, 1'b1);
      end
      set_rr(8, 1'b1);
      @(posedge clk); #1;
      sample(8, sr, rv, bz, s, co, ov);
      check1("bp_release_valid", rv, 1'b0);
      check1("bp_release_ready", sr, 1'b1);
      check1("bp_release_busy", bz, 1'b0);

      // Reset during RUN aborts the operation asynchronously
      drive(8, 1'b1, 32'hAA, 32'h55, 1'b0);
      @(posedge clk); #1;
      drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      sample(8, sr, rv, bz, s, co, ov);
      check1("rst_run_busy", bz, 1'b0);
      check32("rst_run_sum", s, 32'd0);
      check1("rst_run_valid", rv, 1'b0);
      check1("rst_run_ready", sr, 1'b1);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      sample(8, sr, rv, bz, s, co, ov);
      check1("rst_after_ready", sr, 1'b1);
      check1("rst_after_valid", rv, 1'b0);
      do_op(8, 32'h01, 32'h01, 1'b0, s, co, ov, lat);
      check32("rst_fresh_sum", s, 32'h02);
      check1("rst_fresh_cout", co, 1'b0);
      check32("rst_fresh_latency", 32'(lat), 32'd8);
      @(posedge clk); #1;

      // Random back-to-back operations at both widths
      stream(8, 1000);
      stream(3, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
